// File: rtl/hazard_ctrl.sv
// Load-use / branch hazard controller on the ID/EX read side, with a small stall/flush FSM.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cnt / flush_cnt performance counters.
module hazard_ctrl #(
    parameter int unsigned LU_STALLS    = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEMREAD_BIT  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic [4:0] idex_rt,
    input  logic [2:0] idex_m,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       idex_bubble,
    output logic       ifid_flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;

    localparam logic [2:0] LU_LOAD    = 3'(LU_STALLS - 1);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       lu_hit;

    assign lu_hit = idex_m[MEMREAD_BIT] && (idex_rt != 5'd0) &&
                    ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

    // The first stall/flush cycle is answered from RUN, so cnt tracks the remaining ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else if (branch_taken) begin
            if (FLUSH_CYCLES > 1) begin
                state <= FLUSH;
                cnt   <= FLUSH_LOAD;
            end else begin
                state <= RUN;
                cnt   <= '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (lu_hit && (LU_STALLS > 1)) begin
                        state <= LU_STALL;
                        cnt   <= LU_LOAD;
                    end
                end
                LU_STALL, FLUSH: begin
                    if (cnt <= 3'd1) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
        end else if (branch_taken || (state == FLUSH)) begin
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
        end else if ((state == LU_STALL) || ((state == RUN) && lu_hit)) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
            if (ifid_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        assert ((LU_STALLS >= 1) && (LU_STALLS <= 7) &&
                (FLUSH_CYCLES >= 1) && (FLUSH_CYCLES <= 7) && (MEMREAD_BIT <= 2))
        else $error("hazard_ctrl: illegal parameter value");
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: four instances with different stall/flush depths share stimulus.
// Define HAZARD_PERF_CNT_EN to also exercise the performance counters.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, idex_rt;
    logic       id_uses_rt;
    logic [2:0] idex_m;
    logic       branch_taken;
    logic [3:0] pcw, ifw, bub, fl;
    logic [15:0] expv;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc [4];
    logic [31:0] fc [4];
`endif
    int checks = 0;
    int errors = 0;

    // instance g: LU_STALLS = LS[g], FLUSH_CYCLES = FLC[g]
    localparam int unsigned LS  [4] = '{1, 2, 3, 2};
    localparam int unsigned FLC [4] = '{1, 2, 3, 3};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        hazard_ctrl #(
            .LU_STALLS   (LS[g]),
            .FLUSH_CYCLES(FLC[g]),
            .MEMREAD_BIT (1)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .id_rs       (id_rs),
            .id_rt       (id_rt),
            .id_uses_rt  (id_uses_rt),
            .idex_rt     (idex_rt),
            .idex_m      (idex_m),
            .branch_taken(branch_taken),
            .pc_write    (pcw[g]),
            .ifid_write  (ifw[g]),
            .idex_bubble (bub[g]),
            .ifid_flush  (fl[g])
`ifdef HAZARD_PERF_CNT_EN
            ,
            .stall_cnt   (sc[g]),
            .flush_cnt   (fc[g])
`endif
        );
    end

    // 0 idle, 1 rs hazard, 2 hazard on r0, 3 rt hazard, 4 rt match but Rt unused,
    // 5 branch, 6 branch + rs hazard, 7 rs match without MemRead
    task automatic apply(input int code);
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        idex_rt = 5'd0; idex_m = 3'b000; branch_taken = 1'b0;
        case (code)
            1: begin idex_m = 3'b010; idex_rt = 5'd5; id_rs = 5'd5; end
            2: begin idex_m = 3'b010; idex_rt = 5'd0; id_rs = 5'd0; end
            3: begin idex_m = 3'b010; idex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b1; end
            4: begin idex_m = 3'b010; idex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; end
            5: branch_taken = 1'b1;
            6: begin idex_m = 3'b010; idex_rt = 5'd5; id_rs = 5'd5; branch_taken = 1'b1; end
            7: begin idex_m = 3'b101; idex_rt = 5'd5; id_rs = 5'd5; end
            default: ;
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            id_rs = 5'($urandom); id_rt = 5'($urandom); id_uses_rt = 1'($urandom);
            idex_rt = 5'($urandom); idex_m = 3'($urandom); branch_taken = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({pcw, ifw, bub, fl} !== 16'h00FF) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: got %h expected %h", i, {pcw, ifw, bub, fl}, 16'h00FF);
            end
            @(posedge clk); #1;
        end
        apply(0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({pcw, ifw, bub, fl} !== 16'hFF00) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", {pcw, ifw, bub, fl}, 16'hFF00);
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if ({sc[3], fc[3]} !== 64'd0) begin
            errors++;
            $display("FAIL reset_counters: got %h expected 0", {sc[3], fc[3]});
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        int         code [6] = '{1, 0, 0, 0, 2, 0};
        logic [3:0] s    [6] = '{4'b1111, 4'b1110, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            apply(code[i]);
            @(negedge clk);
            expv = {~s[i], ~s[i], s[i], 4'b0000};
            checks++;
            if ({pcw, ifw, bub, fl} !== expv) begin
                errors++;
                $display("FAIL load_use cyc %0d: got %h expected %h", i, {pcw, ifw, bub, fl}, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use_rt();
        int         code [7] = '{3, 0, 0, 0, 4, 7, 0};
        logic [3:0] s    [7] = '{4'b1111, 4'b1110, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            apply(code[i]);
            @(negedge clk);
            expv = {~s[i], ~s[i], s[i], 4'b0000};
            checks++;
            if ({pcw, ifw, bub, fl} !== expv) begin
                errors++;
                $display("FAIL load_use_rt cyc %0d: got %h expected %h", i, {pcw, ifw, bub, fl}, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        int         code [8] = '{5, 0, 0, 0, 6, 0, 0, 0};
        logic [3:0] f    [8] = '{4'b1111, 4'b1110, 4'b1100, 4'b0000,
                                 4'b1111, 4'b1110, 4'b1100, 4'b0000};
        for (int i = 0; i < 8; i++) begin
            apply(code[i]);
            @(negedge clk);
            expv = {4'b1111, 4'b1111, f[i], f[i]};
            checks++;
            if ({pcw, ifw, bub, fl} !== expv) begin
                errors++;
                $display("FAIL branch cyc %0d: got %h expected %h", i, {pcw, ifw, bub, fl}, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort();
        int         code [3] = '{1, 5, 0};
        logic [3:0] s    [3] = '{4'b1111, 4'b0000, 4'b0000};
        logic [3:0] f    [3] = '{4'b0000, 4'b1111, 4'b1110};
        for (int i = 0; i < 3; i++) begin
            apply(code[i]);
            @(negedge clk);
            expv = {~s[i], ~s[i], s[i] | f[i], f[i]};
            checks++;
            if ({pcw, ifw, bub, fl} !== expv) begin
                errors++;
                $display("FAIL abort cyc %0d: got %h expected %h", i, {pcw, ifw, bub, fl}, expv);
            end
            @(posedge clk); #1;
        end
        // instances 2 and 3 are still mid-flush here
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pcw, ifw, bub, fl} !== 16'h00FF) begin
            errors++;
            $display("FAIL abort_reset_hold: got %h expected %h", {pcw, ifw, bub, fl}, 16'h00FF);
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({pcw, ifw, bub, fl} !== 16'hFF00) begin
                errors++;
                $display("FAIL abort_reset_run cyc %0d: got %h expected %h", i, {pcw, ifw, bub, fl}, 16'hFF00);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int         code [5] = '{5, 5, 0, 0, 0};
        logic [3:0] f    [5] = '{4'b1111, 4'b1111, 4'b1110, 4'b1100, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            apply(code[i]);
            @(negedge clk);
            expv = {4'b1111, 4'b1111, f[i], f[i]};
            checks++;
            if ({pcw, ifw, bub, fl} !== expv) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got %h expected %h", i, {pcw, ifw, bub, fl}, expv);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        int code [8] = '{1, 0, 0, 0, 5, 0, 0, 0};
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            apply(code[i]);
            @(posedge clk); #1;
        end
        checks++;
        if ({sc[3], fc[3]} !== {32'd2, 32'd3}) begin
            errors++;
            $display("FAIL perf_l2f3: got stall %0d flush %0d expected 2 3", sc[3], fc[3]);
        end
        checks++;
        if ({sc[0], fc[0]} !== {32'd1, 32'd1}) begin
            errors++;
            $display("FAIL perf_l1f1: got stall %0d flush %0d expected 1 1", sc[0], fc[0]);
        end
        force g_dut[3].u_dut.stall_cnt = 32'hFFFF_FFFE;
        #1 release g_dut[3].u_dut.stall_cnt;
        for (int i = 0; i < 4; i++) begin
            apply((i == 0) ? 1 : 0);
            @(posedge clk); #1;
        end
        checks++;
        if (sc[3] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL perf_saturate: got %h expected ffffffff", sc[3]);
        end
    endtask
`endif

    initial begin
        apply(0);
        test_reset();
        test_load_use();
        test_load_use_rt();
        test_branch();
        test_abort();
        test_back_to_back();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
